// File: rtl/fpmul_result_checker.sv
// Self-checking receiver for the FP multiplier bench: delays expected products by
// LATENCY and scores them against FP_Z. Optional ulp tolerance: FPMUL_CHK_ULP_TOL_EN.
module fpmul_result_checker #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             CLEAR,
  input  logic             IN_VALID,
  input  logic [31:0]      EXP_Z,
  input  logic [31:0]      DUT_Z,
  output logic             CHK_VALID,
  output logic             MATCH,
  output logic [CNT_W-1:0] SAMPLE_CNT,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic             ERR_FLAG,
  output logic [CNT_W-1:0] FIRST_ERR_IDX,
  output logic [31:0]      FIRST_ERR_EXP,
  output logic [31:0]      FIRST_ERR_GOT
`ifdef FPMUL_CHK_ULP_TOL_EN
  ,
  output logic [CNT_W-1:0] ULP_CNT
`endif
);

  localparam int unsigned W = 32;

  logic [LATENCY-1:0]        pipe_v;
  logic [LATENCY-1:0][W-1:0] pipe_exp;
  logic [W-1:0]              last_exp;
  logic                      exp_nan;
  logic                      dut_nan;
  logic                      exact_c;
  logic                      ok_c;
`ifdef FPMUL_CHK_ULP_TOL_EN
  logic                      ulp_c;
  logic                      ulp_hit_c;
  logic [W-2:0]              mag_e;
  logic [W-2:0]              mag_d;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Expected-value delay line; bubbles travel as valid=0, no stall
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      pipe_v   <= '0;
      pipe_exp <= '0;
    end else begin
      pipe_v[0]   <= IN_VALID;
      pipe_exp[0] <= EXP_Z;
      for (int k = 1; k < int'(LATENCY); k++) begin
        pipe_v[k]   <= pipe_v[k-1];
        pipe_exp[k] <= pipe_exp[k-1];
      end
    end
  end

  assign last_exp  = pipe_exp[LATENCY-1];
  assign CHK_VALID = pipe_v[LATENCY-1];

  // Compare: bitwise equality, any-NaN vs any-NaN, optionally one-ulp neighbours
  always_comb begin
    exp_nan = (&last_exp[30:23]) && (|last_exp[22:0]);
    dut_nan = (&DUT_Z[30:23]) && (|DUT_Z[22:0]);
    exact_c = (DUT_Z == last_exp) || (exp_nan && dut_nan);
`ifdef FPMUL_CHK_ULP_TOL_EN
    mag_e     = last_exp[30:0];
    mag_d     = DUT_Z[30:0];
    ulp_c     = (last_exp[31] == DUT_Z[31]) && !(&last_exp[30:23]) && !(&DUT_Z[30:23]) &&
                (((mag_e - mag_d) == 31'd1) || ((mag_d - mag_e) == 31'd1));
    ulp_hit_c = !exact_c && ulp_c;
    ok_c      = exact_c || ulp_c;
`else
    ok_c      = exact_c;
`endif
    MATCH = CHK_VALID && ok_c;
  end

  // Statistics and first-failure record
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      SAMPLE_CNT    <= '0;
      ERR_CNT       <= '0;
      ERR_FLAG      <= 1'b0;
      FIRST_ERR_IDX <= '0;
      FIRST_ERR_EXP <= '0;
      FIRST_ERR_GOT <= '0;
`ifdef FPMUL_CHK_ULP_TOL_EN
      ULP_CNT       <= '0;
`endif
    end else if (CLEAR) begin
      SAMPLE_CNT    <= '0;
      ERR_CNT       <= '0;
      ERR_FLAG      <= 1'b0;
      FIRST_ERR_IDX <= '0;
      FIRST_ERR_EXP <= '0;
      FIRST_ERR_GOT <= '0;
`ifdef FPMUL_CHK_ULP_TOL_EN
      ULP_CNT       <= '0;
`endif
    end else if (CHK_VALID) begin
      SAMPLE_CNT <= sat_inc(SAMPLE_CNT);
      if (!ok_c) begin
        ERR_CNT <= sat_inc(ERR_CNT);
        if (!ERR_FLAG) begin
          ERR_FLAG      <= 1'b1;
          FIRST_ERR_IDX <= SAMPLE_CNT;
          FIRST_ERR_EXP <= last_exp;
          FIRST_ERR_GOT <= DUT_Z;
        end
      end
`ifdef FPMUL_CHK_ULP_TOL_EN
      if (ulp_hit_c) ULP_CNT <= sat_inc(ULP_CNT);
`endif
    end
  end

endmodule

// File: tb/tb_fpmul_result_checker.sv
// Randomised + directed bench for fpmul_result_checker against a queue-based reference.
module tb_fpmul_result_checker;

  localparam int unsigned LAT  = 2;
  localparam int unsigned CW   = 4;
  localparam int          MAXC = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST_n = 1'b0;
  logic          CLEAR = 1'b0;
  logic          IN_VALID = 1'b0;
  logic [31:0]   EXP_Z = '0;
  logic [31:0]   DUT_Z = '0;
  logic          CHK_VALID;
  logic          MATCH;
  logic [CW-1:0] SAMPLE_CNT;
  logic [CW-1:0] ERR_CNT;
  logic          ERR_FLAG;
  logic [CW-1:0] FIRST_ERR_IDX;
  logic [31:0]   FIRST_ERR_EXP;
  logic [31:0]   FIRST_ERR_GOT;
`ifdef FPMUL_CHK_ULP_TOL_EN
  logic [CW-1:0] ULP_CNT;
`endif

  fpmul_result_checker #(.LATENCY(LAT), .CNT_W(CW)) dut (
    .CLK(CLK), .RST_n(RST_n), .CLEAR(CLEAR), .IN_VALID(IN_VALID),
    .EXP_Z(EXP_Z), .DUT_Z(DUT_Z), .CHK_VALID(CHK_VALID), .MATCH(MATCH),
    .SAMPLE_CNT(SAMPLE_CNT), .ERR_CNT(ERR_CNT), .ERR_FLAG(ERR_FLAG),
    .FIRST_ERR_IDX(FIRST_ERR_IDX), .FIRST_ERR_EXP(FIRST_ERR_EXP),
    .FIRST_ERR_GOT(FIRST_ERR_GOT)
`ifdef FPMUL_CHK_ULP_TOL_EN
    , .ULP_CNT(ULP_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  // One entry per clock edge: what was issued and what the DUT will show LAT cycles later
  typedef struct { bit v; bit [31:0] e; bit [31:0] d; } item_t;
  item_t hist[$];

  int n_chk = 0;
  int n_fail = 0;
  int m_sample, m_err, m_ulp;
  bit m_flag;
  bit [31:0] m_idx, m_exp, m_got;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_nan(input bit [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  function automatic bit ref_ulp(input bit [31:0] a, input bit [31:0] b);
    longint ma, mb;
    ma = longint'(a[30:0]);
    mb = longint'(b[30:0]);
    return (a[31] == b[31]) && (a[30:23] != 8'hFF) && (b[30:23] != 8'hFF) &&
           ((ma - mb == 1) || (mb - ma == 1));
  endfunction

  function automatic int sat(input int v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  task automatic model_reset();
    item_t z;
    z.v = 0; z.e = 0; z.d = 0;
    m_sample = 0; m_err = 0; m_ulp = 0; m_flag = 0;
    m_idx = 0; m_exp = 0; m_got = 0;
    hist.delete();
    repeat (LAT) hist.push_back(z);
  endtask

  task automatic check_regs();
    chk("sample_cnt", 32'(SAMPLE_CNT), 32'(m_sample));
    chk("err_cnt", 32'(ERR_CNT), 32'(m_err));
    chk("err_flag", 32'(ERR_FLAG), 32'(m_flag));
    chk("first_idx", 32'(FIRST_ERR_IDX), m_idx);
    chk("first_exp", FIRST_ERR_EXP, m_exp);
    chk("first_got", FIRST_ERR_GOT, m_got);
`ifdef FPMUL_CHK_ULP_TOL_EN
    chk("ulp_cnt", 32'(ULP_CNT), 32'(m_ulp));
`endif
  endtask

  // One clock: drive, check the sample that falls due now, then advance the model
  task automatic cycle(input bit iv, input bit [31:0] e, input bit [31:0] d, input bit clr);
    item_t due, nw;
    bit exact, ulp, ok;
    @(negedge CLK);
    due = hist[0];
    IN_VALID = iv; EXP_Z = e; DUT_Z = due.d; CLEAR = clr;
    #1;
    exact = (due.d == due.e) || (is_nan(due.e) && is_nan(due.d));
`ifdef FPMUL_CHK_ULP_TOL_EN
    ulp = ref_ulp(due.e, due.d);
`else
    ulp = 0;
`endif
    ok = exact || ulp;
    chk("chk_valid", 32'(CHK_VALID), 32'(due.v));
    chk("match", 32'(MATCH), 32'(due.v && ok));
    check_regs();
    if (clr) begin
      m_sample = 0; m_err = 0; m_ulp = 0; m_flag = 0;
      m_idx = 0; m_exp = 0; m_got = 0;
    end else if (due.v) begin
      if (!ok && !m_flag) begin
        m_flag = 1; m_idx = 32'(m_sample); m_exp = due.e; m_got = due.d;
      end
      m_sample = sat(m_sample);
      if (!ok) m_err = sat(m_err);
      if (ulp && !exact) m_ulp = sat(m_ulp);
    end
    nw.v = iv; nw.e = e; nw.d = d;
    hist.push_back(nw);
    void'(hist.pop_front());
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_n = 1'b0; IN_VALID = 1'b0; CLEAR = 1'b0;
    model_reset();
    #1;
    chk("rst_chk_valid", 32'(CHK_VALID), 32'd0);
    chk("rst_match", 32'(MATCH), 32'd0);
    check_regs();
    @(negedge CLK);
    RST_n = 1'b1;
  endtask

  task automatic drain();
    repeat (LAT + 1) cycle(0, 32'h0, 32'h0, 0);
  endtask

  function automatic bit [31:0] rand_word();
    int unsigned r;
    bit [31:0] w;
    r = $urandom_range(0, 9);
    w = $urandom;
    case (r)
      0: w = {w[31], 8'hFF, w[22:1], 1'b1};
      1: w = {w[31], 31'h0};
      2: w = {w[31], 8'hFF, 23'h0};
      default: ;
    endcase
    return w;
  endfunction

  function automatic bit [31:0] rand_dut(input bit [31:0] e);
    bit [31:0] w;
    case ($urandom_range(0, 9))
      6: w = e ^ (32'h1 << $urandom_range(0, 31));
      7: w = e + 32'h1;
      8: w = e - 32'h1;
      9: begin w = $urandom; if (is_nan(e)) w = {w[31], 8'hFF, w[22:1], 1'b1}; end
      default: w = e;
    endcase
    return w;
  endfunction

  initial begin
    bit [31:0] v;
    do_reset();

    // Single sample: visible only in cycle LAT
    cycle(1, 32'h40000000, 32'h40000000, 0);
    drain();
    chk("single_sample_cnt", 32'(SAMPLE_CNT), 32'd1);
    chk("single_err_cnt", 32'(ERR_CNT), 32'd0);

    // Eight-sample stream, bubble after #3, #5 corrupted
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      v = (i == 5) ? 32'h3F800000 : 32'h40000000 + (32'(i) << 16);
      cycle(1, v, (i == 5) ? 32'h3F800002 : v, 0);
      if (i == 3) cycle(0, 32'h0, 32'h0, 0);
    end
    drain();
    chk("stream_sample_cnt", 32'(SAMPLE_CNT), 32'd8);
    chk("stream_err_cnt", 32'(ERR_CNT), 32'd1);
    chk("stream_first_idx", 32'(FIRST_ERR_IDX), 32'd5);
    chk("stream_first_exp", FIRST_ERR_EXP, 32'h3F800000);
    chk("stream_first_got", FIRST_ERR_GOT, 32'h3F800002);

    // NaN equivalence and signed zero
    cycle(0, 0, 0, 1);
    cycle(1, 32'h7FC00000, 32'hFFC00001, 0);
    cycle(1, 32'h00000000, 32'h80000000, 0);
    drain();
    chk("zero_err_flag", 32'(ERR_FLAG), 32'd1);
    chk("nan_zero_err_cnt", 32'(ERR_CNT), 32'd1);
    chk("zero_first_idx", 32'(FIRST_ERR_IDX), 32'd1);

    // Two failures, CLEAR, then a third
    cycle(0, 0, 0, 1);
    cycle(1, 32'h12345678, 32'h12345679 ^ 32'h00F00000, 0);
    cycle(1, 32'h0BADBEEF, 32'h0BADBEE0, 0);
    drain();
    cycle(0, 0, 0, 1);
    cycle(1, 32'h11111111, 32'h22222222, 0);
    drain();
    chk("clr_err_cnt", 32'(ERR_CNT), 32'd1);
    chk("clr_first_idx", 32'(FIRST_ERR_IDX), 32'd0);
    chk("clr_first_exp", FIRST_ERR_EXP, 32'h11111111);
    chk("clr_first_got", FIRST_ERR_GOT, 32'h22222222);

    // Saturation, then capture on a saturated sample count
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 17; i++) begin
      v = 32'h3F000000 + 32'(i);
      cycle(1, v, v, 0);
    end
    cycle(1, 32'h40400000, 32'hC0400000, 0);
    drain();
    chk("sat_sample_cnt", 32'(SAMPLE_CNT), 32'(MAXC));
    chk("sat_first_idx", 32'(FIRST_ERR_IDX), 32'(MAXC));
    chk("sat_err_cnt", 32'(ERR_CNT), 32'd1);

    // One-ulp neighbour
    cycle(0, 0, 0, 1);
    cycle(1, 32'h3F800000, 32'h3F800001, 0);
    drain();
`ifdef FPMUL_CHK_ULP_TOL_EN
    chk("ulp_err_cnt", 32'(ERR_CNT), 32'd0);
    chk("ulp_ulp_cnt", 32'(ULP_CNT), 32'd1);
`else
    chk("ulp_err_cnt", 32'(ERR_CNT), 32'd1);
`endif

    // Reset with two samples in flight
    cycle(1, 32'h40000000, 32'h40000000, 0);
    cycle(1, 32'h40400000, 32'h00000000, 0);
    do_reset();
    drain();
    chk("rst_flush_sample_cnt", 32'(SAMPLE_CNT), 32'd0);
    chk("rst_flush_err_cnt", 32'(ERR_CNT), 32'd0);

    // Random traffic with occasional CLEAR
    for (int i = 0; i < 400; i++) begin
      v = rand_word();
      cycle(($urandom_range(0, 3) != 0), v, rand_dut(v), ($urandom_range(0, 40) == 0));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
